// File: rtl/prng_pkg.sv
// Shared definitions for the LFSR pseudo-random generators.
//   TAPS_W*     : maximal-length Galois feedback masks for common widths
//   galois_next : one Galois LFSR step, computed at MAX_WIDTH bits; callers
//                 zero-extend their state/taps and truncate the result
package prng_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [3:0]  TAPS_W4  = 4'hC;          // x^4+x^3+1
    localparam logic [7:0]  TAPS_W8  = 8'hB8;         // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] TAPS_W32 = 32'h80200003;  // x^32+x^22+x^2+x+1

    // Shift right and fold the taps back in whenever a one falls off the end.
    // Upper bits beyond the caller's width stay zero, so truncation is exact.
    function automatic logic [MAX_WIDTH-1:0] galois_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps
    );
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Sequence-period monitor for the LFSR stream.
// Remembers the origin (last loaded seed), counts accepted steps, and reports
// when the generator steps back onto the origin.
//   clk, rst    : clock, synchronous active-high reset
//   load        : new origin is load_value; restarts the step count
//   load_value  : sanitised (non-zero) seed
//   fire        : a word was accepted this cycle; the state moves to next
//   next        : state the generator will hold after this fire
//   period_done : one-cycle pulse when next equalled the origin
//   period_len  : steps in the last completed period, held until the next one
module lfsr_period_mon #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             fire,
    input  logic [WIDTH-1:0] next,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] origin;
    logic [WIDTH-1:0] count;

    // NOTE: reset is synchronous, so it lives inside the clocked block as an
    // ordinary highest-priority branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            origin      <= SEED;
            count       <= '0;
            period_done <= 1'b0;
            period_len  <= '0;
        end else begin
            period_done <= 1'b0;
            if (load) begin
                // A load overrides any fire in the same cycle.
                origin <= load_value;
                count  <= '0;
            end else if (fire) begin
                if (next == origin) begin
                    period_done <= 1'b1;
                    period_len  <= count + WIDTH'(1);
                    count       <= '0;
                end else begin
                    // Free wrap: a wrapped count simply never reports.
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_prng_stream.sv
// Galois LFSR pseudo-random word stream with run-time seeding, valid/ready
// output handshake and on-chip period measurement.
//   clk, rst    : clock, synchronous active-high reset
//   en          : enable; allows out_valid to (re)assert
//   seed_load   : one-cycle pulse loading seed_in as new state and origin
//   seed_in     : seed value; zero is replaced by SEED
//   out_ready   : consumer ready
//   out_valid   : rand_out holds an unconsumed word
//   rand_out    : current LFSR state
//   seed_zero   : one-cycle pulse when a zero seed was substituted
//   period_done : one-cycle pulse when the sequence returned to its origin
//   period_len  : length of the last completed period
module lfsr_prng_stream
    import prng_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W4),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_out,
    output logic             seed_zero,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic             fire;
    logic [WIDTH-1:0] next;
    logic             seed_is_zero;
    logic [WIDTH-1:0] load_value;

    assign fire         = out_valid & out_ready;
    assign next         = WIDTH'(galois_next(MAX_WIDTH'(rand_out), MAX_WIDTH'(TAPS)));
    // The all-zero state is a lock-up point for an XOR LFSR; never load it.
    assign seed_is_zero = (seed_in == '0);
    assign load_value   = seed_is_zero ? SEED : seed_in;

    // NOTE: every register here is updated with non-blocking assignments so
    // all of them see the pre-edge values of fire/next/out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rand_out  <= SEED;
            out_valid <= 1'b0;
            seed_zero <= 1'b0;
        end else begin
            seed_zero <= 1'b0;
            if (seed_load) begin
                rand_out  <= load_value;
                out_valid <= 1'b0;
                seed_zero <= seed_is_zero;
            end else begin
                if (fire) begin
                    rand_out <= next;
                end
                // A presented word is never retracted: only a fire may clear
                // out_valid, and then only if en has dropped.
                out_valid <= fire ? en : (out_valid | en);
            end
        end
    end

    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_mon (
        .clk         (clk),
        .rst         (rst),
        .load        (seed_load),
        .load_value  (load_value),
        .fire        (fire),
        .next        (next),
        .period_done (period_done),
        .period_len  (period_len)
    );

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: a 4-bit instance exercised through
// stream, back-pressure, seeding, enable and reset steps, with accepted words
// checked against a queue of expected values, plus an 8-bit instance run for
// a full maximal period.
module tb_lfsr_prng_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       seed_load;
    logic [3:0] seed_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] rand_out;
    logic       seed_zero;
    logic       period_done;
    logic [3:0] period_len;

    logic       en8;
    logic       rdy8;
    logic       out_valid8;
    logic [7:0] rand_out8;
    logic       seed_zero8;
    logic       period_done8;
    logic [7:0] period_len8;

    int         total  = 0;
    int         passed = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_prng_stream #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .rand_out    (rand_out),
        .seed_zero   (seed_zero),
        .period_done (period_done),
        .period_len  (period_len)
    );

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .en          (en8),
        .seed_load   (1'b0),
        .seed_in     (8'h00),
        .out_ready   (rdy8),
        .out_valid   (out_valid8),
        .rand_out    (rand_out8),
        .seed_zero   (seed_zero8),
        .period_done (period_done8),
        .period_len  (period_len8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [3:0] w);
        exp_q.push_back(w);
    endtask

    // Drive one cycle of inputs just after a falling edge. If the DUT will
    // accept its word on the coming rising edge, compare it with the queue.
    task automatic tick(input logic e, input logic r, input logic l, input logic [3:0] s);
        en        = e;
        out_ready = r;
        seed_load = l;
        seed_in   = s;
        if (!rst && !l && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", {28'h0, rand_out}, 32'hFFFF_FFFF);
            else                   check("stream_word", {28'h0, rand_out}, {28'h0, exp_q.pop_front()});
        end
        @(negedge clk);
    endtask

    function automatic logic [7:0] step8(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    initial begin
        logic [3:0] seq_from1[15];
        logic [3:0] seq_fromA[15];
        int         pd_seen;
        int         fires8;
        int         zeros8;
        int         bad8;
        logic       done8;
        logic [7:0] m8;

        seq_from1 = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                      4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
        seq_fromA = '{4'hA, 4'h5, 4'hE, 4'h7, 4'hF, 4'hB, 4'h9, 4'h8,
                      4'h4, 4'h2, 4'h1, 4'hC, 4'h6, 4'h3, 4'hD};

        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 4'h0; out_ready = 1'b1;
        en8 = 1'b0; rdy8 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rand_out",    {28'h0, rand_out},   32'h1);
        check("rst_out_valid",   {31'h0, out_valid},  32'h0);
        check("rst_seed_zero",   {31'h0, seed_zero},  32'h0);
        check("rst_period_done", {31'h0, period_done}, 32'h0);
        check("rst_period_len",  {28'h0, period_len}, 32'h0);
        rst = 1'b0;

        // 1: free-running maximal sequence, one-cycle valid latency
        tick(1, 1, 0, 4'h0);
        check("t1_valid_latency", {31'h0, out_valid}, 32'h1);
        pd_seen = 0;
        for (int i = 0; i < 15; i++) begin
            push(seq_from1[i]);
            if (period_done) pd_seen++;
            tick(1, 1, 0, 4'h0);
        end
        check("t1_pd_early",    pd_seen,              0);
        check("t1_period_done", {31'h0, period_done}, 32'h1);
        check("t1_period_len",  {28'h0, period_len},  32'd15);
        check("t1_wrap_word",   {28'h0, rand_out},    32'h1);
        push(4'h1);
        tick(1, 1, 0, 4'h0);
        check("t1_pd_one_cycle", {31'h0, period_done}, 32'h0);
        push(4'hC); push(4'h6);
        tick(1, 1, 0, 4'h0);
        tick(1, 1, 0, 4'h0);

        // 2: back-pressure at rand_out=3
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 4'h0);
            check("t2_hold_word",  {28'h0, rand_out}, 32'h3);
            check("t2_hold_valid", {31'h0, out_valid}, 32'h1);
        end
        push(4'h3); push(4'hD); push(4'hA);
        tick(1, 1, 0, 4'h0);
        tick(1, 1, 0, 4'h0);
        tick(1, 1, 0, 4'h0);
        check("t2_resume_word", {28'h0, rand_out}, 32'h5);

        // 3: seed load of A mid-stream; the concurrent fire is discarded
        tick(1, 1, 1, 4'hA);
        check("t3_load_word",  {28'h0, rand_out},  32'hA);
        check("t3_load_valid", {31'h0, out_valid}, 32'h0);
        check("t3_no_zero",    {31'h0, seed_zero}, 32'h0);
        tick(1, 1, 0, 4'h0);
        check("t3_revalid", {31'h0, out_valid}, 32'h1);
        pd_seen = 0;
        for (int i = 0; i < 15; i++) begin
            push(seq_fromA[i]);
            if (period_done) pd_seen++;
            tick(1, 1, 0, 4'h0);
        end
        check("t3_pd_early",    pd_seen,              0);
        check("t3_period_done", {31'h0, period_done}, 32'h1);
        check("t3_period_len",  {28'h0, period_len},  32'd15);

        // 4: zero seed is substituted by SEED
        tick(1, 1, 1, 4'h0);
        check("t4_seed_zero",  {31'h0, seed_zero}, 32'h1);
        check("t4_subst_word", {28'h0, rand_out},  32'h1);
        check("t4_load_valid", {31'h0, out_valid}, 32'h0);
        tick(1, 1, 0, 4'h0);
        check("t4_seed_zero_pulse", {31'h0, seed_zero}, 32'h0);
        check("t4_revalid",         {31'h0, out_valid}, 32'h1);
        push(4'h1); push(4'hC); push(4'h6);
        tick(1, 1, 0, 4'h0);
        tick(1, 1, 0, 4'h0);
        tick(1, 1, 0, 4'h0);

        // 5: en dropped while the word 3 is stalled
        tick(0, 0, 0, 4'h0);
        check("t5_hold_valid", {31'h0, out_valid}, 32'h1);
        check("t5_hold_word",  {28'h0, rand_out},  32'h3);
        tick(0, 0, 0, 4'h0);
        check("t5_hold_valid2", {31'h0, out_valid}, 32'h1);
        push(4'h3);
        tick(0, 1, 0, 4'h0);
        check("t5_drop_valid", {31'h0, out_valid}, 32'h0);
        check("t5_drop_word",  {28'h0, rand_out},  32'hD);
        tick(0, 1, 0, 4'h0);
        check("t5_stay_low",  {31'h0, out_valid}, 32'h0);
        check("t5_stay_word", {28'h0, rand_out},  32'hD);
        tick(1, 1, 0, 4'h0);
        push(4'hD);
        tick(1, 1, 0, 4'h0);
        check("t5_prerst_len", {28'h0, period_len}, 32'd15);
        rst = 1'b1;
        tick(1, 1, 0, 4'h0);
        check("t5_rst_word",  {28'h0, rand_out},   32'h1);
        check("t5_rst_valid", {31'h0, out_valid},  32'h0);
        check("t5_rst_len",   {28'h0, period_len}, 32'h0);
        rst = 1'b0;
        en  = 1'b0;
        check("sb_drained", exp_q.size(), 0);

        // 6: 8-bit maximal period
        en8 = 1'b1; rdy8 = 1'b1;
        m8 = 8'h01; fires8 = 0; zeros8 = 0; bad8 = 0; done8 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 600 && !done8; i++) begin
            if (period_done8) begin
                done8 = 1'b1;
            end else begin
                if (rand_out8 == 8'h00) zeros8++;
                if (out_valid8 && rdy8) begin
                    if (rand_out8 !== m8) bad8++;
                    m8 = step8(m8);
                    fires8++;
                end
                @(negedge clk);
            end
        end
        check("t6_done_seen",  {31'h0, done8},      32'h1);
        check("t6_fires",      fires8,              255);
        check("t6_period_len", {24'h0, period_len8}, 32'd255);
        check("t6_wrap_word",  {24'h0, rand_out8},  32'h01);
        check("t6_no_zero",    zeros8,              0);
        check("t6_sequence",   bad8,                0);
        check("t6_no_seed_zero", {31'h0, seed_zero8}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lfsr_prng_stream.md
Name: lfsr_prng_stream

Overview:
- Parametrised Galois LFSR pseudo-random generator with run-time seed loading and a valid/ready output stream.
- Measures sequence period on-chip: reports cycle length and flags wrap back to the loaded seed.
- Next-generation replacement for the fixed 4-bit free-running generator.
- Feeds test-pattern, scrambler and stimulus consumers that apply back-pressure.

Parameters:
WIDTH, 4, LFSR state width in bits (legal 3..32).
TAPS, 4'hC, Galois feedback mask, WIDTH bits; default is x^4+x^3+1 (maximal, period 15).
SEED, 4'h1, reset/fallback seed, WIDTH bits, must be non-zero.

Ports:
clk  input  1  rising-edge clock (single clock domain)
rst  input  1  synchronous, active-high reset
en  input  1  generator enable; permits out_valid to (re)assert
seed_load  input  1  one-cycle pulse: load seed_in as new state and origin
seed_in  input  WIDTH  seed value sampled when seed_load=1
out_ready  input  1  consumer ready
out_valid  output  1  rand_out holds a word not yet consumed
rand_out  output  WIDTH  current LFSR state
seed_zero  output  1  one-cycle pulse: all-zero seed_in replaced by SEED
period_done  output  1  one-cycle pulse: sequence returned to origin
period_len  output  WIDTH  steps in last completed period; held until next completion

Behaviour:
- Reset values: rand_out=SEED, origin=SEED, out_valid=0, seed_zero=0, period_done=0, period_len=0, step count=0.
- Step function: next = state[0] ? ((state>>1) ^ TAPS) : (state>>1).
- fire = out_valid & out_ready.
- On fire, rand_out <= next on the following edge.
- rand_out changes only on fire, seed_load or rst; it is stable while out_valid=1 and out_ready=0.
- out_valid:
  - Set to 1 on the edge after a cycle with en=1 and out_valid=0.
  - After fire, remains 1 if en=1 in the fire cycle; otherwise goes to 0.
  - Never drops without a fire (no retraction), except on rst or seed_load.
  - en=0 with out_valid=1 and no fire: valid holds.
- Seed load (takes effect next edge):
  - state and origin <= seed_in, or SEED if seed_in==0; in that case seed_zero pulses 1 cycle.
  - out_valid <= 0 and step count <= 0.
  - Any fire in the same cycle is discarded.
- Period tracking:
  - Step count increments on each fire, wrapping at WIDTH bits.
  - On a fire where next==origin: period_done=1 for one cycle, period_len <= count+1, count <= 0.
  - Non-maximal TAPS produce the true shorter cycle length.
  - If the count wraps before a match, period_len is not updated.
- Priority: rst > seed_load > fire.
- All-zero lock-up is unreachable; the all-zero seed is substituted as above.
- Throughput: one word per cycle with out_ready held at 1. Latency from en rising to out_valid is 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package prng_pkg:
  - Default TAPS constants for widths 4, 8, 16 and 32 (4'hC, 8'hB8, 16'hB400, 32'h80200003).
  - Function galois_next(state, taps).
- Sub-module lfsr_period_mon:
  - Holds origin, step counter and period_done/period_len logic.
  - Inputs: clk, rst, load, load_value, fire, next.
- The top level holds the state register, valid/ready control and seed sanitising.

Test Plan:
1. Reset, then en=1, out_ready=1 (WIDTH=4) -> out_valid=1 after one cycle; rand_out sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1. period_done pulses on the return to 1 with period_len=15.
2. Back-pressure: out_ready=0 for 5 cycles at rand_out=3 -> rand_out holds 3 and out_valid stays 1. Release -> next accepted word is D; no skipped or duplicated values.
3. seed_load=1, seed_in=4'hA mid-stream -> next cycle rand_out=A, out_valid=0, then 1. Sequence A,5,E,7… ; period_done after 15 fires with period_len=15.
4. seed_load with seed_in=0 -> seed_zero pulses once, rand_out=1, no lock-up; the stream continues C,6,…
5. en dropped during a stalled valid word -> out_valid holds until fire, then drops to 0. rst asserted mid-stream -> next cycle rand_out=1, out_valid=0, period_len=0.
6. WIDTH=8, TAPS=8'hB8, SEED=8'h01, out_ready=1 -> period_done after 255 fires with period_len=255. No zero state is ever observed.
